// File: rtl/call_sequencer_if.sv
// Handshake bundle between the call sequencer and its decoder/stack environment.
// master = sequencer side, slave = decoder + return-address stack side.
interface call_sequencer_if #(
   parameter int PC_WIDTH = 16,
   parameter int DEPTH    = 16
);
   localparam int DW = $clog2(DEPTH + 1);

   logic                en;
   logic                halt_req;
   logic                resume;
   logic                jump;
   logic                call_req;
   logic                ret_req;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] return_to;

   logic [PC_WIDTH-1:0] pc;
   logic                call;
   logic                ret;
   logic                stack_clr;
   logic [PC_WIDTH-1:0] called_from;
   logic [DW-1:0]       depth;
   logic                fault;
   logic [1:0]          fault_code;
   logic                halted;

   modport master (
      input  en, halt_req, resume, jump, call_req, ret_req, target, return_to,
      output pc, call, ret, stack_clr, called_from, depth, fault, fault_code, halted
   );

   modport slave (
      output en, halt_req, resume, jump, call_req, ret_req, target, return_to,
      input  pc, call, ret, stack_clr, called_from, depth, fault, fault_code, halted
   );
endinterface

// File: rtl/call_sequencer.sv
// PC sequencer driving a return-address stack; traps overflow/underflow locally
// so the stack's narrow offset never wraps.
module call_sequencer #(
   parameter int PC_WIDTH = 16,
   parameter int DEPTH    = 16,
   parameter int RESET_PC = 0
) (
   input logic             clock,
   input logic             reset,
   call_sequencer_if.master bus
);
   localparam int DW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT, S_FAULT} state_t;

   typedef struct packed {
      logic ret;
      logic call;
      logic jump;
   } req_t;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_OVER  = 2'b01;
   localparam logic [1:0] FC_UNDER = 2'b10;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]       depth_q, depth_d;
   logic [1:0]          fcode_q, fcode_d;
   logic                call_o, ret_o;
   req_t                req;

   assign req = '{ret: bus.ret_req, call: bus.call_req, jump: bus.jump};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_INIT;
         pc_q    <= PC_WIDTH'(RESET_PC);
         depth_q <= '0;
         fcode_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         fcode_q <= fcode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      fcode_d = fcode_q;
      call_o  = 1'b0;
      ret_o   = 1'b0;
      case (state_q)
         // One cycle here gives the stack its synchronous offset clear.
         S_INIT: state_d = S_RUN;
         S_RUN: begin
            if (bus.halt_req) begin
               state_d = S_HALT;
            end else if (bus.en) begin
               if (req.ret) begin
                  if (depth_q == '0) begin
                     state_d = S_FAULT;
                     fcode_d = FC_UNDER;
                  end else begin
                     ret_o   = 1'b1;
                     pc_d    = bus.return_to;
                     depth_d = depth_q - DW'(1);
                  end
               end else if (req.call) begin
                  if (depth_q == DW'(DEPTH)) begin
                     state_d = S_FAULT;
                     fcode_d = FC_OVER;
                  end else begin
                     call_o  = 1'b1;
                     pc_d    = bus.target;
                     depth_d = depth_q + DW'(1);
                  end
               end else if (req.jump) begin
                  pc_d = bus.target;
               end else begin
                  pc_d = pc_q + PC_WIDTH'(1);
               end
            end
         end
         S_HALT: if (bus.resume) state_d = S_RUN;
         S_FAULT: begin
            if (bus.resume) begin
               state_d = S_INIT;
               pc_d    = PC_WIDTH'(RESET_PC);
               depth_d = '0;
               fcode_d = FC_NONE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.called_from = pc_q;
   assign bus.depth       = depth_q;
   assign bus.fault_code  = fcode_q;
   assign bus.call        = call_o;
   assign bus.ret         = ret_o;
   assign bus.stack_clr   = (state_q == S_INIT);
   assign bus.fault       = (state_q == S_FAULT);
   assign bus.halted      = (state_q == S_HALT);
endmodule

// File: tb/tb_call_sequencer.sv
// Directed bench for call_sequencer with a behavioural return-address stack attached.
module tb_call_sequencer;
   localparam int PW = 16;
   localparam int DP = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   call_sequencer_if #(.PC_WIDTH(PW), .DEPTH(DP)) bus ();

   call_sequencer #(.PC_WIDTH(PW), .DEPTH(DP), .RESET_PC(0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Stack stand-in: stores called_from+1 on call, pops on ret, clears on stack_clr.
   logic [PW-1:0] stk [DP];
   logic [4:0]    sp = '0;
   always @(posedge clock) begin
      if (bus.stack_clr) sp <= '0;
      else if (bus.call) begin
         stk[sp[3:0]] <= bus.called_from + 16'd1;
         sp <= sp + 5'd1;
      end else if (bus.ret) sp <= sp - 5'd1;
   end
   assign bus.return_to = (sp == 0) ? '0 : stk[4'(sp - 5'd1)];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.halt_req = 0; bus.resume = 0; bus.jump = 0;
      bus.call_req = 0; bus.ret_req = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.en = 0; bus.target = '0;
      idle();
      repeat (2) tick();
      check("rst_pc", bus.pc, 0);
      check("rst_depth", bus.depth, 0);
      check("rst_fcode", bus.fault_code, 0);
      check("rst_clr", bus.stack_clr, 1);
      check("rst_call", {bus.call, bus.ret}, 0);

      reset = 0; bus.en = 1;
      #1 check("init_clr", bus.stack_clr, 1);
      tick();
      check("run_clr", bus.stack_clr, 0);
      check("run_pc0", bus.pc, 0);
      tick(); tick(); tick();
      check("run_pc3", bus.pc, 3);
      tick(); tick();
      check("run_pc5", bus.pc, 5);

      // Single call/return
      bus.call_req = 1; bus.target = 16'h0040;
      #1 check("call_strobe", {bus.call, bus.ret}, 2'b10);
      check("called_from", bus.called_from, 5);
      tick(); idle();
      check("call_pc", bus.pc, 16'h40);
      check("call_depth", bus.depth, 1);
      tick(); tick(); tick();
      check("idle_pc", bus.pc, 16'h43);
      bus.ret_req = 1;
      #1 check("ret_strobe", {bus.call, bus.ret}, 2'b01);
      tick(); idle();
      check("ret_pc", bus.pc, 6);
      check("ret_depth", bus.depth, 0);

      // Nest to full depth, then overflow
      for (int i = 0; i < DP; i++) begin
         bus.call_req = 1; bus.target = 16'(16'h100 + i);
         tick();
      end
      check("full_depth", bus.depth, 16);
      check("full_pc", bus.pc, 16'h10F);
      bus.target = 16'h0200;
      #1 check("ovf_call_low", bus.call, 0);
      tick(); idle();
      check("ovf_fault", bus.fault, 1);
      check("ovf_code", bus.fault_code, 2'b01);
      check("ovf_pc", bus.pc, 16'h10F);
      tick();
      check("ovf_hold", {bus.fault, bus.depth}, {1'b1, 5'd16});
      bus.resume = 1;
      tick(); idle();
      check("rcv_init", {bus.stack_clr, bus.fault}, 2'b10);
      check("rcv_pc", bus.pc, 0);
      check("rcv_depth", bus.depth, 0);
      check("rcv_code", bus.fault_code, 0);
      tick();
      check("rcv_run_pc", bus.pc, 0);

      // Underflow
      bus.ret_req = 1;
      #1 check("unf_ret_low", bus.ret, 0);
      tick(); idle();
      check("unf_code", {bus.fault, bus.fault_code}, 3'b110);
      check("unf_pc", bus.pc, 0);
      bus.resume = 1;
      tick(); idle();
      tick();

      // ret beats call in the same cycle
      bus.call_req = 1; bus.target = 16'h0020;
      tick(); idle();
      check("d1_depth", bus.depth, 1);
      bus.call_req = 1; bus.ret_req = 1; bus.target = 16'h0300;
      #1 check("prio_strobe", {bus.call, bus.ret}, 2'b01);
      tick(); idle();
      check("prio_pc", bus.pc, 1);
      check("prio_depth", bus.depth, 0);

      // Halt with concurrent jump
      bus.halt_req = 1; bus.jump = 1; bus.target = 16'h0080;
      tick(); idle();
      check("halt_flag", bus.halted, 1);
      check("halt_pc", bus.pc, 1);
      bus.en = 0; tick(); bus.en = 1; bus.halt_req = 1; tick(); idle();
      check("halt_hold", {bus.halted, bus.pc}, {1'b1, 16'd1});
      bus.resume = 1;
      tick(); idle();
      check("resume_pc", bus.pc, 1);
      tick();
      check("resume_inc", {bus.halted, bus.pc}, {1'b0, 16'd2});

      // Stall
      bus.en = 0; bus.jump = 1; bus.target = 16'h1234;
      tick(); idle(); bus.en = 1;
      check("stall_pc", bus.pc, 2);

      // Wrap
      bus.jump = 1; bus.target = 16'hFFFF;
      tick(); idle();
      check("jump_pc", bus.pc, 16'hFFFF);
      tick();
      check("wrap_pc", bus.pc, 0);

      // Async reset in the middle of a call
      bus.call_req = 1; bus.target = 16'h0055;
      tick();
      check("pre_rst_depth", bus.depth, 1);
      bus.target = 16'h0066;
      #2 reset = 1;
      #1 check("arst_pc", bus.pc, 0);
      check("arst_depth", bus.depth, 0);
      check("arst_call", bus.call, 0);
      idle();
      tick();
      reset = 0;
      #1 check("arst_clr", bus.stack_clr, 1);
      tick();
      check("arst_run", {bus.stack_clr, bus.pc}, {1'b0, 16'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/call_sequencer.md
Name: call_sequencer

Overview:
- Program-counter sequencer that initiates traffic on the return-address stack interface.
- Advances the PC and decodes jump, call and return requests from the instruction decoder.
- Drives the stack's call, ret, called_from and synchronous reset inputs, and consumes its return_to output.
- Tracks stack depth locally so overflow and underflow are trapped before they reach the stack, since the stack's 4-bit offset would otherwise silently wrap.

Parameters:
PC_WIDTH, 16, width of program counter and all address ports
DEPTH, 16, stack entries; must match the stack instance
RESET_PC, 0, PC value after reset and after fault recovery

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance enable; low = stall, PC and depth hold
halt_req  input  1  request transition to HALT
resume  input  1  leave HALT, or recover from FAULT
jump  input  1  unconditional jump to target
call_req  input  1  subroutine call to target
ret_req  input  1  return from subroutine
target  input  PC_WIDTH  jump/call destination
return_to  input  PC_WIDTH  top-of-stack return address (combinational from stack)
pc  output  PC_WIDTH  current program counter (registered)
call  output  1  stack push strobe (combinational)
ret  output  1  stack pop strobe (combinational)
stack_clr  output  1  synchronous clear to stack reset input
called_from  output  PC_WIDTH  equals pc at all times
depth  output  $clog2(DEPTH+1)  current nesting depth (registered)
fault  output  1  high while in FAULT
fault_code  output  2  00 none, 01 overflow, 10 underflow; held until recovery
halted  output  1  high while in HALT

Behaviour:
- Reset (async, active-high) forces:
  - state=INIT, pc=RESET_PC, depth=0, fault_code=00.
  - All strobes low except stack_clr.
- FSM states: INIT, RUN, HALT, FAULT. All outputs other than call, ret and called_from are decoded from registered state.
- INIT:
  - stack_clr=1 for exactly one cycle; pc, depth and fault_code hold.
  - Next state is RUN unconditionally. This guarantees the stack's synchronous offset clear after async reset.
- RUN, evaluated each cycle:
  - If halt_req=1: go to HALT. No action is taken and requests in the same cycle are dropped.
  - Else if en=0: hold everything; call and ret stay low.
  - Else act on the highest-priority request (ret > call > jump > increment); lower-priority requests in the same cycle are ignored.
- ret_req:
  - If depth==0: go to FAULT with fault_code=10. ret stays low and pc holds.
  - Otherwise: ret=1 this cycle, pc<=return_to, depth<=depth-1.
- call_req:
  - If depth==DEPTH: go to FAULT with fault_code=01. call stays low and pc holds.
  - Otherwise: call=1 this cycle, pc<=target, depth<=depth+1.
  - The stack stores called_from+1 on the same edge. return_to is therefore valid from the next cycle.
- jump: pc<=target.
- No request: pc<=pc+1, wrapping modulo 2^PC_WIDTH (all-ones -> 0).
- HALT:
  - halted=1; pc and depth hold; call and ret low.
  - resume=1 -> RUN on the next cycle.
  - halt_req is ignored while in HALT.
- FAULT:
  - fault=1; call and ret low; pc, depth and fault_code hold.
  - resume=1 -> INIT with pc<=RESET_PC, depth<=0, fault_code<=00 on the same edge.
- call and ret are never high together and are never high outside RUN.
- Async reset mid-operation (any state) returns to INIT, and the stack is cleared via stack_clr on the following cycle.

Test Plan:
- Reset release, RESET_PC=0 -> stack_clr high for 1 cycle; then pc counts 0,1,2,3 with en=1.
- At pc=5, call_req, target=0x40 -> call=1, called_from=5, next pc=0x40, depth=1. Idle 3 cycles (pc=0x43), then ret_req -> ret=1, next pc=6, depth=0.
- Nested: 16 calls succeed (depth=16). 17th call_req -> call stays low, fault=1, fault_code=01, pc unchanged. resume -> INIT, then pc=0, depth=0.
- ret_req at depth=0 -> ret low, fault_code=10. Same cycle with call_req and ret_req at depth=1 -> only ret=1, depth=0.
- halt_req together with jump, target=0x80 -> HALT, pc unchanged, halted=1. en toggled -> no change. resume -> RUN, pc increments.
- pc=0xFFFF, no request -> pc=0x0000. Async reset asserted mid-cycle during call -> pc=0 immediately, depth=0, stack_clr after release.
